// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM states and op encoding.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand and result handshakes for serial_add_sub; the master drives operands, the slave computes.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, overflow
  );
endinterface

// File: rtl/serial_add_sub_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;
  logic g1;
  logic g2;

  assign p    = x ^ y;
  assign g1   = x & y;
  assign s    = p ^ cin;
  assign g2   = p & cin;
  assign cout = g1 | g2;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: LSB-first through one full-adder cell and a carry flop,
// with valid/ready handshakes on operands and result.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_sub_if.slave io
);
  localparam int unsigned     CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    bit_cnt;
  logic             carry_ff;
  logic             carry_msb;
  logic             op_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .x    (shift_a[0]),
    .y    (shift_b[0]),
    .cin  (carry_ff),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_a     <= '0;
      shift_b     <= '0;
      res_q       <= '0;
      bit_cnt     <= '0;
      carry_ff    <= 1'b0;
      carry_msb   <= 1'b0;
      op_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            shift_a    <= io.a;
            shift_b    <= (io.op == OP_SUB) ? ~io.b : io.b;
            carry_ff   <= io.op;
            op_q       <= io.op;
            bit_cnt    <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          res_q    <= {fa_s, res_q[WIDTH-1:1]};
          shift_a  <= shift_a >> 1;
          shift_b  <= shift_b >> 1;
          carry_ff <= fa_co;
          bit_cnt  <= bit_cnt + CW'(1);
          if (bit_cnt == CNT_PRE) begin
            carry_msb <= fa_co;
          end
          // carry_msb was captured on the previous edge, so it is valid here even for WIDTH=2.
          if (bit_cnt == CNT_LAST) begin
            carry_q     <= fa_co ^ op_q;
            ovf_q       <= carry_msb ^ fa_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = res_q;
  assign io.carry     = carry_q;
  assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomized checks of serial_add_sub at WIDTH=8.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  serial_add_sub_if #(.WIDTH(8)) io ();

  serial_add_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic o);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    if (o == OP_ADD) begin
      s = {1'b0, x} + {1'b0, y};
      r = s[7:0];
      c = s[8];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      r = x - y;
      c = (x < y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
    return {v, c, r};
  endfunction

  // Drives one transaction; returns {overflow,carry,result}, cycles from accept to out_valid, and ok=0 on timeout.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic top, input int stall,
                        output logic [9:0] got, output int lat, output bit ok);
    int n;
    ok  = 1'b1;
    got = '0;
    lat = 0;
    n   = 0;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.in_ready) begin
      ok = 1'b0;
      return;
    end
    io.in_valid = 1'b1;
    io.a        = ta;
    io.b        = tb_;
    io.op       = top;
    @(negedge clk);
    io.in_valid = 1'b0;
    io.a        = ~ta;
    io.b        = ~tb_;
    io.op       = ~top;
    while (!io.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!io.out_valid) begin
      ok = 1'b0;
      return;
    end
    got = {io.overflow, io.carry, io.result};
    repeat (stall) @(negedge clk);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    got = {io.in_ready, io.out_valid, io.carry, io.overflow, |io.result};
    vecs++;
    if (got !== 5'b10000) begin
      errs++;
      $display("FAIL reset_outputs {in_ready,out_valid,carry,ovf,|result} got=%b exp=%b", got, 5'b10000);
    end
    vecs++;
    if (io.result !== 8'h00) begin
      errs++;
      $display("FAIL reset_result got=%h exp=%h", io.result, 8'h00);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta[5]  = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tbv[5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       to[5]  = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [9:0] te[5]  = '{10'b0_0_00010000, 10'b0_1_00000000, 10'b1_0_10000000,
                           10'b0_1_11111110, 10'b1_0_01111111};
    logic [9:0] got;
    int         lat;
    bit         ok;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tbv[i], to[i], 0, got, lat, ok);
      vecs++;
      if (!ok || got !== te[i]) begin
        errs++;
        $display("FAIL directed_%0d {ovf,carry,result} got=%b exp=%b ok=%0d", i, got, te[i], ok);
      end
      vecs++;
      if (lat != 8) begin
        errs++;
        $display("FAIL latency_%0d got=%0d exp=8", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a        = 8'h3C;
    io.b        = 8'h11;
    io.op       = OP_ADD;
    @(negedge clk);
    io.a  = 8'hFF;
    io.b  = 8'hFF;
    io.op = OP_SUB;
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (!io.out_valid) begin
      errs++;
      $display("FAIL bp_timeout out_valid got=0 exp=1");
    end
    for (int i = 0; i < 5; i++) begin
      io.in_valid = (i % 2 == 0);
      io.a        = 8'h01;
      io.b        = 8'h02;
      io.op       = OP_ADD;
      @(negedge clk);
      vecs++;
      if ({io.out_valid, io.in_ready, io.overflow, io.carry, io.result} !== {4'b1000, 8'h4D}) begin
        errs++;
        $display("FAIL bp_hold_%0d {ov,ir,ovf,c,res} got=%b exp=%b", i,
                 {io.out_valid, io.in_ready, io.overflow, io.carry, io.result}, {4'b1000, 8'h4D});
      end
    end
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    vecs++;
    if ({io.out_valid, io.in_ready} !== 2'b01) begin
      errs++;
      $display("FAIL bp_handoff {out_valid,in_ready} got=%b exp=01", {io.out_valid, io.in_ready});
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    vecs++;
    if (io.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_next_accept in_ready got=%b exp=0", io.in_ready);
    end
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (!io.out_valid || io.result !== 8'h03) begin
      errs++;
      $display("FAIL bp_next_result got=%h exp=%h valid=%b", io.result, 8'h03, io.out_valid);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    int         lat;
    bit         ok;
    bit         seen;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a        = 8'hAA;
    io.b        = 8'h55;
    io.op       = OP_ADD;
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({io.out_valid, io.in_ready, io.result} !== {2'b01, 8'h00}) begin
      errs++;
      $display("FAIL mid_reset {out_valid,in_ready,result} got=%b exp=%b",
               {io.out_valid, io.in_ready, io.result}, {2'b01, 8'h00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL mid_reset_stray out_valid got=1 exp=0");
    end
    run_op(8'h01, 8'h01, OP_ADD, 0, got, lat, ok);
    vecs++;
    if (!ok || got !== 10'h002) begin
      errs++;
      $display("FAIL after_reset_add got=%b exp=%b ok=%0d", got, 10'h002, ok);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       ro;
    logic [9:0] got;
    logic [9:0] exp;
    int         lat;
    bit         ok;
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      ro  = 1'($urandom);
      exp = model(ra, rb, ro);
      run_op(ra, rb, ro, int'($urandom_range(0, 3)), got, lat, ok);
      vecs++;
      if (!ok || got !== exp) begin
        errs++;
        $display("FAIL random_%0d a=%h b=%h op=%b got=%b exp=%b ok=%0d", i, ra, rb, ro, got, exp, ok);
      end
    end
  endtask

  initial begin
    vecs         = 0;
    errs         = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.op        = 1'b0;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
